cpu_dma_arbiter: RTL
====================

Name: cpu_dma_arbiter

Overview:
- Shares the single SDRAM DMA port between NUM_REQ CPU-side bus masters: the USB DMA engine (index 0) and the SD card DMA engine (index 1).
- Sits in cpu_soc between the peripheral DMA engines and the memory-side DMA interface.
- Arbitration is round-robin, with optional burst locking and a registered request path to memory.
- Exposes a status word for the CPU register block.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 26, memory word-address width
DATA_W, 16, memory data width
TIMEOUT, 1023, max cycles waiting for mem_ack (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_i  in  NUM_REQ  per-requester access request, level, held until ack
req_write_i  in  NUM_REQ  1=write, 0=read
req_lock_i  in  NUM_REQ  hold grant after this access (burst)
req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
req_wdata_i  in  NUM_REQ*DATA_W  packed write data
req_ack_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
req_rdata_o  out  DATA_W  read data, broadcast, valid with req_ack_o
mem_request_o  out  1  memory access request
mem_write_o  out  1  memory write strobe qualifier
mem_address_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completion pulse
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
grant_o  out  NUM_REQ  one-hot current owner, 0 when idle
error_o  out  1  sticky timeout flag
error_clear_i  in  1  clears error_o

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer = 0.
  - Reset mid-access drops mem_request_o immediately. Memory is expected to be reset in the same domain.
- States: IDLE, ISSUE, LOCKED.
- IDLE:
  - If any req_i is set, select the first set bit scanning upward from pointer+1, wrapping modulo NUM_REQ. The scan starts at 0 after reset, which selects requester 0 first.
  - Next cycle: grant_o is one-hot, mem_request_o=1, and mem_address_o/mem_wdata_o/mem_write_o are registered from the winner. Request-to-mem_request latency is 1 cycle.
  - Go to ISSUE and set pointer = winner.
- ISSUE:
  - Hold mem_* stable until mem_ack_i.
  - On the mem_ack_i cycle, req_ack_o[winner] = 1 and req_rdata_o = mem_rdata_i, combinationally in the same cycle. mem_request_o = 0 from the next cycle.
  - On the ack cycle, if req_lock_i[winner] = 1, go to LOCKED; otherwise clear grant_o and go to IDLE.
- LOCKED:
  - grant_o is held.
  - If req_i[winner] = 1, register its request and go to ISSUE (1 cycle).
  - If req_lock_i[winner] = 0 and req_i[winner] = 0, release to IDLE.
  - Other requesters are starved while LOCKED by design. Burst length is bounded by the requester.
- A requester dropping req_i while in ISSUE is a protocol violation. The access completes regardless and the ack is still pulsed.
- Simultaneous requests: the round-robin pointer guarantees alternation. With both 0 and 1 continuously requesting, the order is 0,1,0,1.
- mem_ack_i outside ISSUE is ignored.
- error_clear_i and a timeout in the same cycle: the set wins.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined, a counter runs in ISSUE and resets on entry. If it reaches TIMEOUT without mem_ack_i:
  - mem_request_o drops;
  - req_ack_o[winner] pulses with req_rdata_o = 0;
  - error_o is set;
  - grant is released to IDLE regardless of lock.
- When undefined, there is no counter, ISSUE waits forever, and error_o is tied 0.

Decomposition:
- Package sc64 (shared):
  - enum e_arb_state {IDLE, ISSUE, LOCKED};
  - constants ID_DMA_USB=0, ID_DMA_SD=1.
- Sub-module cpu_dma_arbiter_rr: combinational round-robin priority picker with inputs req vector and pointer, and output one-hot winner plus a valid bit.

Test Plan:
- Single read: req_i=01, addr0=0x0001234. Expected: mem_request_o rises 1 cycle later with mem_address_o=0x0001234. Memory acks after 3 cycles with rdata 0xBEEF. Expected: req_ack_o=01 for one cycle and req_rdata_o=0xBEEF.
- Contention: req_i=11 held for 4 accesses. Expected: grant sequence 01,10,01,10 and each ack pulse only to the granted index.
- Burst lock: requester 1 with lock=1 does 4 writes (wdata 0x0000..0x0003) while requester 0 requests. Expected: requester 0 is granted only after lock drops, and memory sees exactly 4 writes from requester 1 first.
- Reset mid-access: assert reset while in ISSUE. Expected: mem_request_o=0, grant_o=0, and the first post-reset grant goes to requester 0.
- ARB_TIMEOUT_EN with TIMEOUT=15 and memory never acking. Expected: ack pulse at cycle 15 of ISSUE, error_o=1, and error_clear_i clears it next cycle.
- mem_ack_i pulsed while IDLE. Expected: no req_ack_o, no state change.

Source files
------------

// File: rtl/sc64.sv
// sc64: shared SoC types for the CPU-side DMA arbiter.
// Arbiter FSM states and DMA requester indices.
package sc64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    LOCKED = 2'd2
  } e_arb_state;

  localparam int ID_DMA_USB = 0;
  localparam int ID_DMA_SD  = 1;

endpackage

// File: rtl/cpu_dma_arbiter_rr.sv
// cpu_dma_arbiter_rr: combinational round-robin picker.
// Scans req_i upward from start_i, wrapping, and reports the first hit.
module cpu_dma_arbiter_rr #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  int          j;
  logic [IW-1:0] jw;

  // first requester at or after start_i, modulo N
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    jw      = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      jw = IW'(j);
      if (!valid_o && req_i[jw]) begin
        valid_o   = 1'b1;
        idx_o     = jw;
        gnt_o[jw] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_dma_arbiter.sv
// cpu_dma_arbiter: round-robin share of the SDRAM DMA port with burst lock.
// Optional ack timeout with sticky error_o when ARB_TIMEOUT_EN is defined.
module cpu_dma_arbiter
  import sc64::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic                      mem_request_o,
  output logic                      mem_write_o,
  output logic [ADDR_W-1:0]         mem_address_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic                      mem_ack_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      error_o,
  input  logic                      error_clear_i
);

  localparam int IW = $clog2(NUM_REQ);

  e_arb_state          state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IW-1:0]       win_q;
  logic [IW-1:0]       ptr_q;
  logic                fresh_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic [IW-1:0]       scan_start;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic [IW-1:0]       sel_idx;
  logic                in_issue;
  logic                tmo;
  logic                ack_fire;

  // scan from 0 until the first grant, then from the slot after the last winner
  assign scan_start = fresh_q ? '0 :
                      (ptr_q == IW'(NUM_REQ - 1)) ? '0 : ptr_q + 1'b1;

  cpu_dma_arbiter_rr #(
    .N (NUM_REQ)
  ) u_rr (
    .req_i   (req_i),
    .start_i (scan_start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign sel_idx  = (state_q == IDLE) ? pick_idx : win_q;
  assign in_issue = (state_q == ISSUE);
  assign ack_fire = in_issue && (mem_ack_i || tmo);

  assign req_ack_o   = ack_fire ? grant_q : '0;
  assign req_rdata_o = (in_issue && mem_ack_i) ? mem_rdata_i : '0;

  assign grant_o       = grant_q;
  assign mem_request_o = mem_req_q;
  assign mem_write_o   = mem_we_q;
  assign mem_address_o = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign tmo     = in_issue && !mem_ack_i && (cnt_q == CW'(TIMEOUT));
  assign error_o = err_q;

  // ISSUE cycle counter, parked at 1 so the first ISSUE cycle counts as 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!in_issue) begin
      cnt_q <= CW'(1);
    end else if (cnt_q != CW'(TIMEOUT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // sticky error flag; a new timeout beats a clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= tmo | (err_q & ~error_clear_i);
    end
  end
`else
  logic unused_cfg;

  assign tmo        = 1'b0;
  assign error_o    = 1'b0;
  assign unused_cfg = error_clear_i ^ TIMEOUT[0];
`endif

  // arbitration FSM with registered memory-side request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      win_q       <= '0;
      ptr_q       <= IW'(ID_DMA_USB);
      fresh_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q     <= ISSUE;
            grant_q     <= pick_gnt;
            win_q       <= pick_idx;
            ptr_q       <= pick_idx;
            fresh_q     <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_write_i[sel_idx];
            mem_addr_q  <= req_addr_i[sel_idx*ADDR_W +: ADDR_W];
            mem_wdata_q <= req_wdata_i[sel_idx*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          if (mem_ack_i || tmo) begin
            mem_req_q <= 1'b0;
            if (mem_ack_i && req_lock_i[win_q]) begin
              state_q <= LOCKED;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (req_i[win_q]) begin
            state_q     <= ISSUE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_write_i[sel_idx];
            mem_addr_q  <= req_addr_i[sel_idx*ADDR_W +: ADDR_W];
            mem_wdata_q <= req_wdata_i[sel_idx*DATA_W +: DATA_W];
          end else if (!req_lock_i[win_q]) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
